k12a_clock_gen: RTL and testbench

//   Parametrised CPU clock generator; replaces the fixed divide-by-2 clock control.

---
 rtl/k12a_clock_gen_pkg.sv | 17 +
 rtl/k12a_clock_gen.sv | 120 ++++++++++++
 tb/tb_k12a_clock_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/k12a_clock_gen_pkg.sv
// ---------------------------------------------------------------------------
// k12a_clock_gen_pkg
//   Shared types and constants for the K12A CPU clock generator.
//   clock_state_t        : CPU clock FSM states (high phase, low phase, halted)
//   K12A_CLOCK_DIV_RESET : reset value of the latched divide ratio
// ---------------------------------------------------------------------------
package k12a_clock_gen_pkg;

  typedef enum logic [1:0] {
    CS_HIGH   = 2'd0,
    CS_LOW    = 2'd1,
    CS_HALTED = 2'd2
  } clock_state_t;

  localparam int unsigned K12A_CLOCK_DIV_RESET = 0;

endpackage

// File: rtl/k12a_clock_gen.sv
// ---------------------------------------------------------------------------
// k12a_clock_gen
//   CPU clock generator. Divides sys_clock by a run-time ratio that is
//   latched once per CPU cycle (at the cpu_clock rising edge), produces the
//   async RAM write strobe and counts CPU cycles.
//
//   Optional debug halt / single-step, enabled with `define K12A_CLOCK_DEBUG_EN.
//   Without it halt_req/step_req are ignored and halted is tied low.
//
// Ports
//   sys_clock   in   system clock, all state changes on posedge
//   reset_n     in   asynchronous active-low reset
//   div_half    in   [DIV_WIDTH] phase length minus 1, in sys_clock cycles
//   halt_req    in   level, halt with cpu_clock low at end of current cycle
//   step_req    in   one-cycle pulse, run one CPU cycle while halted
//   cpu_clock   out  registered divided clock
//   async_write out  write strobe, first half of last sys cycle of low phase
//   halted      out  high while halted
//   cpu_cycles  out  [CYC_WIDTH] count of cpu_clock rising edges (wraps)
// ---------------------------------------------------------------------------
module k12a_clock_gen
  import k12a_clock_gen_pkg::*;
#(
  parameter int DIV_WIDTH = 4,
  parameter int CYC_WIDTH = 16
) (
  input  logic                 sys_clock,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] div_half,
  input  logic                 halt_req,
  input  logic                 step_req,
  output logic                 cpu_clock,
  output logic                 async_write,
  output logic                 halted,
  output logic [CYC_WIDTH-1:0] cpu_cycles
);

  clock_state_t         state, state_nxt;
  logic [DIV_WIDTH-1:0] phase_cnt, phase_nxt;
  logic [DIV_WIDTH-1:0] div_q, div_nxt;
  logic [CYC_WIDTH-1:0] cyc_nxt;
  logic                 halt_en;
  logic                 release_en;
  logic                 rise;

`ifdef K12A_CLOCK_DEBUG_EN
  assign halt_en    = halt_req;
  assign release_en = ~halt_req | step_req;
  assign halted     = (state == CS_HALTED);
`else
  logic unused_debug;
  assign unused_debug = ^{halt_req, step_req};
  assign halt_en      = 1'b0;
  assign release_en   = 1'b1;
  assign halted       = 1'b0;
`endif

  // Next-state decode. A "rise" (entry to CS_HIGH) is the only point where
  // the divide ratio is sampled, so mid-cycle div_half changes wait for it.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    div_nxt   = div_q;
    cyc_nxt   = cpu_cycles;
    rise      = 1'b0;
    case (state)
      CS_HIGH: begin
        if (phase_cnt != '0) begin
          phase_nxt = phase_cnt - 1'b1;
        end else begin
          state_nxt = CS_LOW;
          phase_nxt = div_q;
        end
      end
      CS_LOW: begin
        if (phase_cnt != '0) begin
          phase_nxt = phase_cnt - 1'b1;
        end else if (halt_en) begin
          state_nxt = CS_HALTED;
        end else begin
          rise = 1'b1;
        end
      end
      CS_HALTED: begin
        // A step leaves halt for one cycle; halt_req is re-checked at the
        // end of that low phase, which brings the FSM straight back here.
        if (release_en) rise = 1'b1;
      end
      default: rise = 1'b1;
    endcase
    if (rise) begin
      state_nxt = CS_HIGH;
      div_nxt   = div_half;
      phase_nxt = div_half;
      cyc_nxt   = cpu_cycles + 1'b1;
    end
  end

  // cpu_clock comes from the next state so it is a clean register output.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CS_LOW;
      phase_cnt  <= '0;
      div_q      <= DIV_WIDTH'(K12A_CLOCK_DIV_RESET);
      cpu_clock  <= 1'b0;
      cpu_cycles <= '0;
    end else begin
      state      <= state_nxt;
      phase_cnt  <= phase_nxt;
      div_q      <= div_nxt;
      cpu_clock  <= (state_nxt == CS_HIGH);
      cpu_cycles <= cyc_nxt;
    end
  end

  // Strobe occupies the sys_clock-high half of the final low-phase cycle;
  // reset_n gating kills it at once if reset lands mid-pulse.
  assign async_write = reset_n & sys_clock & (state == CS_LOW) & (phase_cnt == '0);

endmodule

// File: tb/tb_k12a_clock_gen.sv
module tb_k12a_clock_gen;

  localparam int DW = 4;
  localparam int CW = 4;

  logic          sys_clock = 1'b0;
  logic          reset_n   = 1'b0;
  logic [DW-1:0] div_half  = '0;
  logic          halt_req  = 1'b0;
  logic          step_req  = 1'b0;
  logic          cpu_clock;
  logic          async_write;
  logic          halted;
  logic [CW-1:0] cpu_cycles;

  int checks = 0;
  int errors = 0;
  int exp_cyc = 0;

  k12a_clock_gen #(.DIV_WIDTH(DW), .CYC_WIDTH(CW)) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .div_half   (div_half),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .cpu_clock  (cpu_clock),
    .async_write(async_write),
    .halted     (halted),
    .cpu_cycles (cpu_cycles)
  );

  always #5 sys_clock = ~sys_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge, while sys_clock is still high.
  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  // Starting just before a rising edge (low phase end or halted), run one
  // CPU cycle of h high + h low sys cycles. chg_at >= 0 changes div_half
  // after that many+1 high cycles to show the change is deferred.
  task automatic expect_cycle(input int h, input int chg_at, input logic [DW-1:0] new_div);
    for (int i = 0; i < h; i++) begin
      tick();
      if (i == 0) exp_cyc++;
      chk("hi_clk", 32'(cpu_clock), 32'd1);
      chk("hi_aw", 32'(async_write), 32'd0);
      chk("hi_halted", 32'(halted), 32'd0);
      if (i == chg_at) div_half = new_div;
    end
    for (int i = 0; i < h; i++) begin
      tick();
      chk("lo_clk", 32'(cpu_clock), 32'd0);
      chk("lo_aw", 32'(async_write), (i == h - 1) ? 32'd1 : 32'd0);
    end
    chk("cycles", 32'(cpu_cycles), 32'(exp_cyc % 16));
  endtask

  int bad;
  int writes;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_clk", 32'(cpu_clock), 32'd0);
    chk("rst_cyc", 32'(cpu_cycles), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_aw", 32'(async_write), 32'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;

    // Divide-by-2
    for (int k = 0; k < 10; k++) expect_cycle(1, -1, '0);
    chk("div2_cyc10", 32'(cpu_cycles), 32'd10);

    // 4/4, then change ratio mid-high: current stays 4/4, next 2/2
    div_half = 4'd3;
    expect_cycle(4, -1, '0);
    expect_cycle(4, 1, 4'd1);
    expect_cycle(2, -1, '0);
    chk("div_cyc13", 32'(cpu_cycles), 32'd13);

`ifdef K12A_CLOCK_DEBUG_EN
    // Halt requested mid-high phase
    div_half = 4'd2;
    tick(); exp_cyc++;
    chk("h3_hi0", 32'(cpu_clock), 32'd1);
    halt_req = 1'b1;
    tick(); chk("h3_hi1", 32'(cpu_clock), 32'd1);
    tick(); chk("h3_hi2", 32'(cpu_clock), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h3_lo_clk", 32'(cpu_clock), 32'd0);
      chk("h3_lo_aw", 32'(async_write), (i == 2) ? 32'd1 : 32'd0);
    end
    tick();
    chk("h3_halted", 32'(halted), 32'd1);
    chk("h3_clk", 32'(cpu_clock), 32'd0);
    bad = 0;
    repeat (20) begin
      tick();
      if (async_write || cpu_clock || !halted) bad++;
    end
    chk("h3_quiet", 32'(bad), 32'd0);
    halt_req = 1'b0;
    tick(); exp_cyc++;
    chk("h3_release_clk", 32'(cpu_clock), 32'd1);
    chk("h3_release_halted", 32'(halted), 32'd0);
    chk("h3_cyc", 32'(cpu_cycles), 32'(exp_cyc % 16));
    repeat (5) tick();
    halt_req = 1'b1;
    tick();
    chk("h4_halted", 32'(halted), 32'd1);

    // Three single steps with halt held
    writes = 0;
    for (int s = 0; s < 3; s++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      exp_cyc++;
      chk("step_clk", 32'(cpu_clock), 32'd1);
      chk("step_halted0", 32'(halted), 32'd0);
      repeat (2) tick();
      chk("step_hi_end", 32'(cpu_clock), 32'd1);
      for (int i = 0; i < 3; i++) begin
        tick();
        if (async_write) writes++;
      end
      tick();
      chk("step_halted1", 32'(halted), 32'd1);
    end
    chk("step_writes", 32'(writes), 32'd3);
    chk("step_cyc", 32'(cpu_cycles), 32'(exp_cyc % 16));
    halt_req = 1'b0;
    expect_cycle(3, -1, '0);
`else
    // halt_req has no effect without the debug build
    div_half = 4'd2;
    halt_req = 1'b1;
    expect_cycle(3, -1, '0);
    expect_cycle(3, -1, '0);
    chk("nodbg_halted", 32'(halted), 32'd0);
    halt_req = 1'b0;
`endif

    // Reset mid-strobe
    div_half = 4'd3;
    expect_cycle(4, -1, '0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst5_aw", 32'(async_write), 32'd0);
    chk("rst5_clk", 32'(cpu_clock), 32'd0);
    chk("rst5_cyc", 32'(cpu_cycles), 32'd0);
    chk("rst5_halted", 32'(halted), 32'd0);
    repeat (3) tick();
    chk("rst5_hold_clk", 32'(cpu_clock), 32'd0);
    chk("rst5_hold_cyc", 32'(cpu_cycles), 32'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;
    exp_cyc = 0;
    div_half = '0;

    // Counter wrap with 4-bit width
    for (int k = 0; k < 17; k++) expect_cycle(1, -1, '0);
    chk("wrap_cyc", 32'(cpu_cycles), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
